// File: rtl/wb_master_pkg.sv
// Shared types and defaults for the Ibex data-side to Wishbone B4 pipelined bridge.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } wb_state_e;

  localparam int unsigned DEF_MAX_OUTSTANDING = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 255;
  localparam int unsigned WB_DW               = 32;
  // Wide enough for the largest supported MAX_OUTSTANDING (7).
  localparam int unsigned OUT_W               = 3;

  typedef struct packed {
    logic             err;
    logic [WB_DW-1:0] rdata;
  } wb_resp_t;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ibex_wb_master_if.sv
// Wishbone B4 pipelined bus bundle between the bridge (master) and its slaves.
interface ibex_wb_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   data_m;
  logic [DW-1:0]   data_s;
  logic            ack;
  logic            err;
  logic            stall;

  modport master (
    output cyc, stb, we, addr, sel, data_m,
    input  data_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, addr, sel, data_m,
    output data_s, ack, err, stall
  );
endinterface

// File: rtl/wb_watchdog.sv
// Loadable saturating cycle counter; expire_o flags the LIMIT-th consecutive enabled cycle.
module wb_watchdog
  import wb_master_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CW    = cnt_width(LIMIT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          expire_o
);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] LAST    = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A LIMIT of zero disables expiry entirely.
  assign expire_o = (LIMIT != 0) && en_i && !clr_i && !load_i && (cnt_q == LAST);

endmodule

// File: rtl/ibex_wb_master.sv
// Ibex data-side req/gnt/rvalid to Wishbone B4 pipelined master with
// outstanding-transfer tracking and a bus-timeout abort path.
module ibex_wb_master
  import wb_master_pkg::*;
#(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = WB_DW,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            data_req_i,
  output logic            data_gnt_o,
  input  logic [AW-1:0]   data_addr_i,
  input  logic            data_we_i,
  input  logic [DW/8-1:0] data_be_i,
  input  logic [DW-1:0]   data_wdata_i,
  output logic            data_rvalid_o,
  output logic [DW-1:0]   data_rdata_o,
  output logic            data_err_o,
  ibex_wb_master_if.master wb
);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  wb_state_e        state_q;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_d;
  logic             rvalid_q;
  wb_resp_t         resp_q;
  wb_resp_t         resp_d;

  logic stb;
  logic accept;
  logic resp_hit;
  logic drain;
  logic wd_en;
  logic expire;

  // Gated by rst_ni so the strobe falls the instant reset is asserted.
  assign stb    = rst_ni && data_req_i && (state_q != ABORT) && (out_q < MAX_OUT);
  assign accept = stb && !wb.stall;

  assign wb.stb    = stb;
  assign wb.cyc    = stb || ((out_q != '0) && (state_q != ABORT));
  assign wb.we     = data_we_i;
  assign wb.addr   = data_addr_i;
  assign wb.sel    = data_be_i;
  assign wb.data_m = data_wdata_i;

  assign data_gnt_o    = accept;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = resp_q.rdata;
  assign data_err_o    = resp_q.err;

  assign resp_hit = (wb.ack || wb.err) && (out_q != '0) && (state_q == ACTIVE);
  // While aborting, each cycle retires one outstanding transfer as an error.
  assign drain    = (state_q == ABORT) && (out_q != '0);

  always_comb begin
    out_d = out_q;
    if (accept && !resp_hit) begin
      out_d = out_q + 1'b1;
    end else if (!accept && (resp_hit || drain)) begin
      out_d = out_q - 1'b1;
    end
  end

  always_comb begin
    resp_d = '0;
    if (drain) begin
      resp_d.err = 1'b1;
    end else if (wb.err) begin
      resp_d.err   = 1'b1;
      resp_d.rdata = wb.ack ? '0 : wb.data_s;
    end else begin
      resp_d.rdata = wb.data_s;
    end
  end

  assign wd_en = (state_q == ACTIVE) && (out_q != '0) && !resp_hit;

  wb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (!wd_en),
    .en_i       (wd_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .expire_o   (expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      out_q    <= '0;
      rvalid_q <= 1'b0;
      resp_q   <= '0;
    end else begin
      out_q    <= out_d;
      rvalid_q <= resp_hit || drain;
      if (resp_hit || drain) begin
        resp_q <= resp_d;
      end else begin
        resp_q.err <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (expire) begin
            state_q <= ABORT;
          end else if (out_d == '0) begin
            state_q <= IDLE;
          end
        end
        ABORT: begin
          if (out_d == '0) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_wb_master.sv
// Self-checking bench: table-driven single transfers, hand-written multi-cycle
// corner sequences, then randomized traffic against a queue-based reference model.
module tb_ibex_wb_master;

  localparam int MAX_OUT = 2;
  localparam int TMO     = 8;

  logic        clk;
  logic        rst_ni;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        derr;

  int checks = 0;
  int errors = 0;

  ibex_wb_master_if #(.AW(32), .DW(32)) wb_bus ();

  ibex_wb_master #(
    .AW              (32),
    .DW              (32),
    .MAX_OUTSTANDING (MAX_OUT),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .data_err_o    (derr),
    .wb            (wb_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall_cyc;   // cycles stall is held before the grant cycle
    int          ack_lat;     // cycles from accept to the slave response (>=1)
    logic        ack;
    logic        err;
    logic [31:0] data_s;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    wb_bus.ack = 1'b0; wb_bus.err = 1'b0; wb_bus.stall = 1'b0; wb_bus.data_s = '0;
  endtask

  // One cycle of read-request / slave-response stimulus, stall kept low.
  task automatic cyc_in(input logic r, input logic [31:0] a, input logic k,
                        input logic e, input logic [31:0] ds);
    tick();
    req = r; addr = a; we = 1'b0; be = 4'hF; wdata = '0;
    wb_bus.ack = k; wb_bus.err = e; wb_bus.stall = 1'b0; wb_bus.data_s = ds;
    settle();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    for (int c = 0; c <= v.stall_cyc; c++) begin
      tick();
      req = 1'b1; we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
      wb_bus.stall = (c < v.stall_cyc);
      settle();
      chk("issue_stb", 32'(wb_bus.stb), 32'(1'b1));
      chk("issue_gnt", 32'(gnt), 32'(c == v.stall_cyc));
      chk("issue_addr", wb_bus.addr, v.addr);
      chk("issue_sel", 32'(wb_bus.sel), 32'(v.be));
      chk("issue_data", wb_bus.data_m, v.wdata);
      chk("issue_we", 32'(wb_bus.we), 32'(v.we));
    end
    tick();
    idle_in();
    for (int d = 1; d < v.ack_lat; d++) begin
      settle();
      chk("wait_cyc", 32'(wb_bus.cyc), 32'(1'b1));
      chk("wait_rvalid", 32'(rvalid), 32'(1'b0));
      tick();
    end
    wb_bus.ack = v.ack; wb_bus.err = v.err; wb_bus.data_s = v.data_s;
    settle();
    chk("ack_rvalid", 32'(rvalid), 32'(1'b0));
    tick();
    idle_in();
    settle();
    chk("resp_rvalid", 32'(rvalid), 32'(1'b1));
    chk("resp_err", 32'(derr), 32'(v.exp_err));
    chk("resp_rdata", rdata, v.exp_rdata);
    chk("resp_cyc", 32'(wb_bus.cyc), 32'(1'b0));
    tick();
    settle();
    chk("resp_pulse", 32'(rvalid), 32'(1'b0));
    $display("txn %0d: addr=0x%08h we=%0d err=%0d rdata=0x%08h", idx, v.addr, v.we, derr, rdata);
  endtask

  // Reference model state for the randomized phase.
  logic [31:0] q_addr[$];
  bit          m_rv;
  bit          m_err;
  logic [31:0] m_rdata;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{we:1'b0, be:4'hF, addr:32'h1000_0004, wdata:32'h0, stall_cyc:0, ack_lat:2,
                ack:1'b1, err:1'b0, data_s:32'hDEAD_BEEF, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF};
    vecs[1] = '{we:1'b1, be:4'h3, addr:32'h2000_0010, wdata:32'h0000_1234, stall_cyc:3, ack_lat:1,
                ack:1'b1, err:1'b0, data_s:32'h0, exp_err:1'b0, exp_rdata:32'h0};
    vecs[2] = '{we:1'b0, be:4'hF, addr:32'h3000_0008, wdata:32'h0, stall_cyc:1, ack_lat:3,
                ack:1'b0, err:1'b1, data_s:32'h0000_0077, exp_err:1'b1, exp_rdata:32'h0000_0077};
    vecs[3] = '{we:1'b0, be:4'hF, addr:32'h4000_000C, wdata:32'h0, stall_cyc:0, ack_lat:2,
                ack:1'b1, err:1'b1, data_s:32'hCAFE_F00D, exp_err:1'b1, exp_rdata:32'h0};
    vecs[4] = '{we:1'b0, be:4'hC, addr:32'h5000_0000, wdata:32'h0, stall_cyc:2, ack_lat:1,
                ack:1'b1, err:1'b0, data_s:32'h0123_4567, exp_err:1'b0, exp_rdata:32'h0123_4567};

    // Reset state.
    rst_ni = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    settle();
    chk("rst_cyc", 32'(wb_bus.cyc), 32'(1'b0));
    chk("rst_stb", 32'(wb_bus.stb), 32'(1'b0));
    chk("rst_gnt", 32'(gnt), 32'(1'b0));
    chk("rst_rvalid", 32'(rvalid), 32'(1'b0));
    chk("rst_err", 32'(derr), 32'(1'b0));
    chk("rst_rdata", rdata, 32'h0);
    rst_ni = 1'b1;

    // Table-driven single transfers.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
    end

    // Pipelined back-to-back reads with a two-deep limit.
    cyc_in(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0);
    chk("pipe_gnt0", 32'(gnt), 32'(1'b1));
    cyc_in(1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0);
    chk("pipe_gnt1", 32'(gnt), 32'(1'b1));
    chk("pipe_cyc1", 32'(wb_bus.cyc), 32'(1'b1));
    cyc_in(1'b1, 32'hA000_0008, 1'b0, 1'b0, 32'h0);
    chk("pipe_full_stb", 32'(wb_bus.stb), 32'(1'b0));
    chk("pipe_full_gnt", 32'(gnt), 32'(1'b0));
    chk("pipe_cyc2", 32'(wb_bus.cyc), 32'(1'b1));
    cyc_in(1'b1, 32'hA000_0008, 1'b1, 1'b0, 32'h1111_0000);
    chk("pipe_ack0_gnt", 32'(gnt), 32'(1'b0));
    chk("pipe_cyc3", 32'(wb_bus.cyc), 32'(1'b1));
    cyc_in(1'b1, 32'hA000_0008, 1'b1, 1'b0, 32'h2222_0000);
    chk("pipe_gnt2", 32'(gnt), 32'(1'b1));
    chk("pipe_rv0", 32'(rvalid), 32'(1'b1));
    chk("pipe_rd0", rdata, 32'h1111_0000);
    cyc_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_0000);
    chk("pipe_rv1", 32'(rvalid), 32'(1'b1));
    chk("pipe_rd1", rdata, 32'h2222_0000);
    chk("pipe_cyc5", 32'(wb_bus.cyc), 32'(1'b1));
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("pipe_rv2", 32'(rvalid), 32'(1'b1));
    chk("pipe_rd2", rdata, 32'h3333_0000);
    chk("pipe_cyc_end", 32'(wb_bus.cyc), 32'(1'b0));
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("pipe_rv_end", 32'(rvalid), 32'(1'b0));
    $display("txn pipe: 3 reads, responses 0x11110000 0x22220000 0x33330000 expected in order");

    // Timeout: two outstanding reads, slave silent.
    cyc_in(1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'h0);
    chk("tmo_gnt0", 32'(gnt), 32'(1'b1));
    cyc_in(1'b1, 32'hB000_0004, 1'b0, 1'b0, 32'h0);
    chk("tmo_gnt1", 32'(gnt), 32'(1'b1));
    for (int k = 2; k <= TMO; k++) begin
      cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("tmo_wait_cyc", 32'(wb_bus.cyc), 32'(1'b1));
      chk("tmo_wait_rv", 32'(rvalid), 32'(1'b0));
    end
    cyc_in(1'b1, 32'hB000_0008, 1'b0, 1'b0, 32'h0);
    chk("tmo_abort_cyc", 32'(wb_bus.cyc), 32'(1'b0));
    chk("tmo_abort_stb", 32'(wb_bus.stb), 32'(1'b0));
    chk("tmo_abort_gnt", 32'(gnt), 32'(1'b0));
    cyc_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h5A5A_5A5A);
    chk("tmo_err1_rv", 32'(rvalid), 32'(1'b1));
    chk("tmo_err1_err", 32'(derr), 32'(1'b1));
    chk("tmo_err1_rd", rdata, 32'h0);
    chk("tmo_err1_cyc", 32'(wb_bus.cyc), 32'(1'b0));
    cyc_in(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    chk("tmo_err2_rv", 32'(rvalid), 32'(1'b1));
    chk("tmo_err2_err", 32'(derr), 32'(1'b1));
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("tmo_late_ack_rv", 32'(rvalid), 32'(1'b0));
    chk("tmo_idle_cyc", 32'(wb_bus.cyc), 32'(1'b0));
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("tmo_quiet_rv", 32'(rvalid), 32'(1'b0));
    $display("txn timeout: 2 reads aborted with error responses");

    // Reset with one transfer outstanding.
    cyc_in(1'b1, 32'hC000_0000, 1'b0, 1'b0, 32'h0);
    chk("mrst_gnt", 32'(gnt), 32'(1'b1));
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("mrst_cyc_before", 32'(wb_bus.cyc), 32'(1'b1));
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst_cyc", 32'(wb_bus.cyc), 32'(1'b0));
    chk("mrst_stb", 32'(wb_bus.stb), 32'(1'b0));
    chk("mrst_rvalid", 32'(rvalid), 32'(1'b0));
    cyc_in(1'b1, 32'hC000_0004, 1'b1, 1'b0, 32'h9999_9999);
    chk("mrst_req_stb", 32'(wb_bus.stb), 32'(1'b0));
    chk("mrst_ack_rv", 32'(rvalid), 32'(1'b0));
    cyc_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("mrst_rv2", 32'(rvalid), 32'(1'b0));
    rst_ni = 1'b1;
    run_vec(vecs[0], 5);

    // Randomized traffic against the queue model.
    begin
      bit   last_gnt = 1'b0;
      int   quiet = 0;
      int   kind;
      bit   e_stb, e_gnt, e_cyc, resp;
      q_addr.delete();
      m_rv = 1'b0; m_err = 1'b0; m_rdata = '0;
      for (int n = 0; n < 400; n++) begin
        tick();
        if (!req || last_gnt) begin
          req   = ($urandom_range(0, 9) < 6);
          addr  = $urandom & 32'hFFFF_FFFC;
          we    = 1'($urandom_range(0, 1));
          be    = 4'($urandom_range(1, 15));
          wdata = $urandom;
        end
        wb_bus.stall  = ($urandom_range(0, 3) == 0);
        wb_bus.data_s = $urandom;
        wb_bus.ack    = 1'b0;
        wb_bus.err    = 1'b0;
        if (q_addr.size() > 0 && (quiet >= 4 || $urandom_range(0, 1) == 1)) begin
          kind = $urandom_range(0, 9);
          wb_bus.ack = (kind < 7) || (kind == 9);
          wb_bus.err = (kind >= 7);
        end else if (q_addr.size() == 0 && $urandom_range(0, 9) == 0) begin
          wb_bus.ack = 1'b1;
        end
        settle();
        e_stb = req && (q_addr.size() < MAX_OUT);
        e_gnt = e_stb && !wb_bus.stall;
        e_cyc = e_stb || (q_addr.size() > 0);
        chk("rnd_stb", 32'(wb_bus.stb), 32'(e_stb));
        chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
        chk("rnd_cyc", 32'(wb_bus.cyc), 32'(e_cyc));
        chk("rnd_rvalid", 32'(rvalid), 32'(m_rv));
        if (m_rv) begin
          chk("rnd_err", 32'(derr), 32'(m_err));
          chk("rnd_rdata", rdata, m_rdata);
        end
        if (req) begin
          chk("rnd_addr", wb_bus.addr, addr);
        end
        resp = (wb_bus.ack || wb_bus.err) && (q_addr.size() > 0);
        quiet = (q_addr.size() > 0 && !resp) ? quiet + 1 : 0;
        if (resp) begin
          m_err   = wb_bus.err;
          m_rdata = (wb_bus.ack && wb_bus.err) ? 32'h0 : wb_bus.data_s;
          void'(q_addr.pop_front());
        end
        if (e_gnt) begin
          q_addr.push_back(addr);
        end
        m_rv = resp;
        last_gnt = e_gnt;
      end
      $display("txn random: 400 cycles of mixed traffic, %0d still outstanding", q_addr.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_wb_master.md
Name: ibex_wb_master

Overview:
- Bridges the Ibex core data-side request interface (req/gnt/rvalid) to a Wishbone B4 pipelined master.
- Sits directly upstream of the Wishbone slaves, including the timer slave. It drives cyc/stb/we/addr/sel/data_m and consumes ack/err/stall/data_s.
- Tracks outstanding transfers and provides a bus-timeout watchdog, so a silent slave cannot hang the core.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered Wishbone transfers (1..7).
- TIMEOUT_CYCLES, 255, cycles with no response while outstanding > 0 before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; also drives the Wishbone interface clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_req_i  in  1  core request; held with its attributes until data_gnt_o.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  AW  byte address.
- data_we_i  in  1  write enable.
- data_be_i  in  DW/8  byte enables.
- data_wdata_i  in  DW  write data.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  DW  read data.
- data_err_o  out  1  response is an error (valid with rvalid).
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle, strobe and write.
- wb_addr_o  out  AW  Wishbone address.
- wb_sel_o  out  DW/8  Wishbone byte select.
- wb_data_m_o  out  DW  Wishbone write data.
- wb_data_s_i  in  DW  Wishbone read data.
- wb_ack_i, wb_err_i, wb_stall_i  in  1  Wishbone slave response and stall.

Behaviour:
- Clocking and reset: one clock, clk_i. Asynchronous active-low reset rst_ni.
- Reset values: all outputs 0, outstanding count 0, watchdog count 0, state IDLE.
- Issue:
  - wb_stb_o = data_req_i && state!=ABORT && outstanding<MAX_OUTSTANDING.
  - we/addr/sel/data_m are combinational pass-through of the core request.
  - data_gnt_o = wb_stb_o && !wb_stall_i; this is the accept event. Issue latency is 0 cycles.
- wb_cyc_o = wb_stb_o || (outstanding!=0 && state!=ABORT).
- Response:
  - On (wb_ack_i || wb_err_i) with outstanding>0 and state ACTIVE, the next cycle presents data_rvalid_o=1.
  - data_rdata_o = registered wb_data_s_i; data_err_o = registered wb_err_i.
  - Latency is 1 cycle after ack. At most one response per cycle. rvalid is a single-cycle pulse.
- ack and err in the same cycle: treated as err; rdata is don't-care, driven 0.
- ack/err with outstanding==0, or in ABORT: ignored, no rvalid.
- Outstanding counter: +1 on accept, -1 on a counted response. A simultaneous accept and response leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- Watchdog:
  - Counts cycles while outstanding>0 and no response arrives.
  - Clears on any counted response or when outstanding==0.
  - Reaching TIMEOUT_CYCLES enters ABORT.
- FSM (enum in package):
  - IDLE -> ACTIVE on accept.
  - ACTIVE -> IDLE when outstanding returns to 0.
  - ACTIVE -> ABORT on timeout.
  - ABORT: cyc/stb forced 0, no grants. Emits one rvalid with data_err_o=1 per cycle, decrementing outstanding. Goes to IDLE the cycle after the last error response.
- A late ack after abort falls in a dropped cycle and is ignored.
- Reset mid-transfer: all state cleared immediately; cyc drops asynchronously, no responses produced.

Decomposition:
- Package wb_master_pkg holds:
  - the state enum {IDLE, ACTIVE, ABORT};
  - the default localparams for MAX_OUTSTANDING and TIMEOUT_CYCLES;
  - the response-struct typedef {err, rdata}.
- Sub-module wb_watchdog: loadable saturating counter with clear/enable inputs and an expire output. Everything else stays flat in ibex_wb_master.

Test Plan:
- Single read: req addr 0x1000_0004, slave acks 2 cycles later with data_s 0xDEAD_BEEF -> gnt same cycle as stb, rvalid one cycle after ack, rdata 0xDEAD_BEEF, err 0, cyc low after.
- Stall: wb_stall_i high 3 cycles on a write (be 0x3, wdata 0x1234) -> gnt only on the 4th cycle, addr/sel/data stable throughout, one ack gives one rvalid.
- Pipelined back-to-back: 3 reads, MAX_OUTSTANDING=2 -> third gnt held until the first ack; responses in order; cyc continuously high; counter peaks at 2.
- Error/ack collision: slave drives ack and err together -> rvalid with data_err_o=1, rdata 0.
- Timeout: TIMEOUT_CYCLES=8, 2 outstanding, slave silent:
  - ABORT on the 8th idle cycle, cyc=0;
  - two consecutive error rvalids, then IDLE;
  - a subsequent ack is ignored.
- Reset mid-transfer: rst_ni low with 1 outstanding -> cyc/stb/rvalid 0 immediately. After release, a new read completes normally.
